// File: rtl/equalize_frame_sequencer.sv
// Frame sequencer for the histogram-equalization engine: HIST -> CDF -> DIV -> OUT -> FIN.
// Define EQ_SEQ_WATCHDOG_EN to add a per-wait-phase watchdog that drives the sticky error output.
module equalize_frame_sequencer #(
  parameter int unsigned PIXELS    = 65536,
  parameter int unsigned WD_CYCLES = 1048575,
  parameter int unsigned WD_W      = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        abort,
  output logic        hist_start,
  input  logic        hist_done,
  output logic        cdf_start,
  input  logic        cdf_done,
  input  logic [19:0] cdf_min_in,
  output logic        out_start,
  input  logic        out_done,
  output logic [19:0] CdfMin,
  output logic [19:0] divisor,
  output logic        output_base_offset,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, HIST, CDF, DIV, OUT, FIN} state_t;

  state_t      state, nxt;
  logic        nxt_hist_start, nxt_cdf_start, nxt_out_start, nxt_frame_done, nxt_off;
  logic [19:0] nxt_cdf_min, nxt_div;
  logic        timeout;

`ifdef EQ_SEQ_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt;
  logic            wait_st, wd_clr;

  assign wait_st = state inside {HIST, CDF, OUT};
  assign wd_clr  = (nxt != state) && (nxt inside {HIST, CDF, OUT});
  assign timeout = wait_st && (wd_cnt == WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        wd_cnt <= '0;
    else if (wd_clr)  wd_cnt <= '0;
    else if (wait_st) wd_cnt <= wd_cnt + 1'b1;
  end

  // Set only when the timeout actually forced the return to IDLE (abort and done win).
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               error <= 1'b0;
    else if (timeout && !abort && nxt == IDLE) error <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // A *_start register still high marks the strobe cycle, so its done input is ignored then.
  always_comb begin
    nxt            = state;
    nxt_hist_start = 1'b0;
    nxt_cdf_start  = 1'b0;
    nxt_out_start  = 1'b0;
    nxt_frame_done = 1'b0;
    nxt_cdf_min    = CdfMin;
    nxt_div        = divisor;
    nxt_off        = output_base_offset;
    case (state)
      IDLE: if (frame_start) begin
        nxt            = HIST;
        nxt_hist_start = 1'b1;
      end
      HIST: begin
        if (abort) nxt = IDLE;
        else if (hist_done && !hist_start) begin
          nxt           = CDF;
          nxt_cdf_start = 1'b1;
        end else if (timeout) nxt = IDLE;
      end
      CDF: begin
        if (abort) nxt = IDLE;
        else if (cdf_done && !cdf_start) begin
          nxt         = DIV;
          nxt_cdf_min = cdf_min_in;
        end else if (timeout) nxt = IDLE;
      end
      DIV: begin
        if (abort) nxt = IDLE;
        else begin
          nxt           = OUT;
          nxt_out_start = 1'b1;
          nxt_div       = (32'(CdfMin) >= PIXELS) ? 20'd1 : 20'(PIXELS - 32'(CdfMin));
        end
      end
      OUT: begin
        if (abort) nxt = IDLE;
        else if (out_done && !out_start) begin
          nxt            = FIN;
          nxt_frame_done = 1'b1;
          nxt_off        = ~output_base_offset;
        end else if (timeout) nxt = IDLE;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      hist_start         <= 1'b0;
      cdf_start          <= 1'b0;
      out_start          <= 1'b0;
      frame_done         <= 1'b0;
      CdfMin             <= '0;
      divisor            <= '0;
      output_base_offset <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state              <= nxt;
      hist_start         <= nxt_hist_start;
      cdf_start          <= nxt_cdf_start;
      out_start          <= nxt_out_start;
      frame_done         <= nxt_frame_done;
      CdfMin             <= nxt_cdf_min;
      divisor            <= nxt_div;
      output_base_offset <= nxt_off;
      busy               <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_equalize_frame_sequencer.sv
// Bench for equalize_frame_sequencer: per-frame results are queued at frame_start and
// compared when frame_done fires; phase timing is checked inline.
module tb_equalize_frame_sequencer;
  logic        clock = 1'b0, reset = 1'b1;
  logic        frame_start = 1'b0, abort = 1'b0;
  logic        hist_done = 1'b0, cdf_done = 1'b0, out_done = 1'b0;
  logic [19:0] cdf_min_in = '0;
  logic        hist_start, cdf_start, out_start, output_base_offset, busy, frame_done, error;
  logic [19:0] CdfMin, divisor;

  typedef struct packed {
    logic [19:0] cmin;
    logic [19:0] div;
    logic        off;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic exp_off = 1'b0;
  int   n_cmp = 0, n_bad = 0;
  int   n_hs = 0, n_os = 0, n_starts = 0, n_outs = 0;

  always #5 clock = ~clock;

  equalize_frame_sequencer #(.PIXELS(65536), .WD_CYCLES(16), .WD_W(20)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .abort(abort),
    .hist_start(hist_start), .hist_done(hist_done),
    .cdf_start(cdf_start), .cdf_done(cdf_done), .cdf_min_in(cdf_min_in),
    .out_start(out_start), .out_done(out_done),
    .CdfMin(CdfMin), .divisor(divisor), .output_base_offset(output_base_offset),
    .busy(busy), .frame_done(frame_done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model_div(input logic [19:0] m);
    int d;
    d = 65536 - int'(m);
    return (m >= 20'd65536) ? 20'd1 : d[19:0];
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (hist_start) n_hs++;
      if (out_start)  n_os++;
      if (frame_done) begin
        if (sb.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("sb_cdfmin", CdfMin, mon_e.cmin);
          chk("sb_divisor", divisor, mon_e.div);
          chk("sb_offset", output_base_offset, mon_e.off);
        end
      end
    end
  end

  // Drives one frame; returns in the FIN cycle (or in IDLE when abrt is set).
  task automatic run_frame(input logic [19:0] cmin, input int lat, input bit hold,
                           input bit spur, input bit abrt);
    int t;
    if (!abrt) begin
      exp_off = ~exp_off;
      sb.push_back({cmin, model_div(cmin), exp_off});
    end
    n_starts++;
    n_outs++;
    frame_start = 1'b1;
    @(negedge clock);
    if (!hold) frame_start = 1'b0;
    chk("hist_start", hist_start, 1);
    chk("busy_hist", busy, 1);
    t = lat;
    if (spur) begin
      hist_done = 1'b1;
      @(negedge clock);
      hist_done = 1'b0;
      chk("spur_hist_ignored", cdf_start, 0);
      t = lat - 1;
    end
    repeat (t) @(negedge clock);
    hist_done = 1'b1;
    @(negedge clock);
    hist_done = 1'b0;
    chk("cdf_start", cdf_start, 1);
    t = lat;
    if (spur) begin
      @(negedge clock);
      out_done = 1'b1;
      @(negedge clock);
      out_done = 1'b0;
      chk("spur_out_busy", busy, 1);
      t = lat - 2;
    end
    repeat (t) @(negedge clock);
    cdf_min_in = cmin;
    cdf_done   = 1'b1;
    @(negedge clock);
    cdf_done = 1'b0;
    chk("cdfmin_reg", CdfMin, cmin);
    chk("div_no_strobe", out_start, 0);
    @(negedge clock);
    chk("out_start", out_start, 1);
    chk("divisor", divisor, model_div(cmin));
    repeat (lat) @(negedge clock);
    out_done = 1'b1;
    abort    = abrt;
    @(negedge clock);
    out_done = 1'b0;
    abort    = 1'b0;
    if (abrt) begin
      chk("abort_busy", busy, 0);
      chk("abort_no_done", frame_done, 0);
      chk("abort_offset", output_base_offset, exp_off);
    end else begin
      chk("frame_done", frame_done, 1);
      chk("fin_busy", busy, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {hist_start, cdf_start, out_start, frame_done}, 0);
    chk("rst_cdfmin", CdfMin, 0);
    chk("rst_divisor", divisor, 0);
    chk("rst_offset", output_base_offset, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("idle_abort", busy, 0);

    // nominal
    run_frame(20'd100, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("nom_idle", busy, 0);
    chk("nom_offset", output_base_offset, 1);

    // back-to-back with frame_start held
    run_frame(20'd200, 1, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk("b2b_gap_strobe", hist_start, 0);
    chk("b2b_gap_busy", busy, 0);
    run_frame(20'd300, 2, 1'b0, 1'b0, 1'b0);
    @(negedge clock);

    // divide-by-zero guard and boundaries
    run_frame(20'd65536, 2, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    run_frame(20'd70000, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    run_frame(20'd65535, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    run_frame(20'd0, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);

    // abort with out_done in OUT, then stray dones in IDLE
    run_frame(20'd555, 2, 1'b0, 1'b0, 1'b1);
    hist_done = 1'b1; cdf_done = 1'b1; out_done = 1'b1;
    repeat (3) @(negedge clock);
    hist_done = 1'b0; cdf_done = 1'b0; out_done = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_strobes", {hist_start, cdf_start, out_start, frame_done}, 0);

    // abort with hist_done in HIST: values from the last DIV stay
    frame_start = 1'b1; n_starts++;
    @(negedge clock);
    frame_start = 1'b0;
    @(negedge clock);
    abort = 1'b1; hist_done = 1'b1;
    @(negedge clock);
    abort = 1'b0; hist_done = 1'b0;
    chk("abort_hist_busy", busy, 0);
    chk("abort_hist_cdf", cdf_start, 0);
    chk("abort_keep_cdfmin", CdfMin, 555);
    chk("abort_keep_div", divisor, model_div(20'd555));

    // spurious done pulses
    run_frame(20'd1234, 3, 1'b0, 1'b1, 1'b0);
    @(negedge clock);

    // reset mid-frame
    frame_start = 1'b1; n_starts++;
    @(negedge clock);
    frame_start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_offset", output_base_offset, 0);
    chk("midrst_cdfmin", CdfMin, 0);
    chk("midrst_div", divisor, 0);
    exp_off = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

`ifdef EQ_SEQ_WATCHDOG_EN
    frame_start = 1'b1; n_starts++;
    @(negedge clock);
    frame_start = 1'b0;
    repeat (15) @(negedge clock);
    chk("wd_before_err", error, 0);
    chk("wd_before_busy", busy, 1);
    @(negedge clock);
    chk("wd_err", error, 1);
    chk("wd_idle", busy, 0);
    repeat (5) @(negedge clock);
    chk("wd_sticky", error, 1);
    run_frame(20'd42, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("wd_sticky_after_frame", error, 1);
`else
    frame_start = 1'b1; n_starts++;
    @(negedge clock);
    frame_start = 1'b0;
    repeat (20) @(negedge clock);
    chk("nowd_error", error, 0);
    chk("nowd_busy", busy, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("nowd_abort_idle", busy, 0);
`endif

    repeat (3) @(negedge clock);
    chk("hist_start_count", n_hs, n_starts);
    chk("out_start_count", n_os, n_outs);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
